// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-class execute/memory/writeback states, driving the datapath strobes.
// Optional feature: define MIPS_MULTICYCLE_JAL_EN to enable the JAL state
// (PC+4 written to $31 while jumping); otherwise opcode 000011 is illegal.
module mips_multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ula_operation,
  output logic [1:0] RegDst,
  output logic [3:0] state,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StIExec    = 4'd10,
    StIWb      = 4'd11,
    StJal      = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [2:0] UlaAdd   = 3'b000;
  localparam logic [2:0] UlaSub   = 3'b001;
  localparam logic [2:0] UlaRType = 3'b010;

  state_e state_q, state_d;
  // Branch flavour captured in DECODE so opcode changes during BRANCH are ignored
  logic   bne_q, bne_d;

  // State register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bne_q   <= bne_d;
    end
  end

  // Next-state and strobe decode; every output defaults to 0
  always_comb begin
    state_d       = state_q;
    bne_d         = bne_q;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    BranchNE      = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    ALUSrcA       = 1'b0;
    RegWrite      = 1'b0;
    PCSource      = 2'b00;
    ALUSrcB       = SrcBReg;
    ula_operation = UlaAdd;
    RegDst        = 2'b00;
    instr_done    = 1'b0;

    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) state_d = StDecode;
      end

      StDecode: begin
        // ALU precomputes PC + (imm << 2) for a possible branch
        ALUSrcB = SrcBImmSh;
        bne_d   = (opcode == OpBne);
        case (opcode)
          OpRType:     state_d = StRExec;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:         state_d = StJump;
`ifdef MIPS_MULTICYCLE_JAL_EN
          OpJal:       state_d = StJal;
`endif
          OpAddi:      state_d = StIExec;
          default: begin
            // Unknown opcode retires as a NOP
            state_d    = StFetch;
            instr_done = 1'b1;
          end
        endcase
      end

      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      end

      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end

      StMemWb: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end

      StRExec: begin
        ALUSrcA       = 1'b1;
        ula_operation = UlaRType;
        state_d       = StRWb;
      end

      StRWb: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StIExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = StIWb;
      end

      StIWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StBranch: begin
        ALUSrcA       = 1'b1;
        ula_operation = UlaSub;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        BranchNE      = bne_q;
        instr_done    = 1'b1;
        state_d       = StFetch;
      end

      StJump: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StJal: begin
`ifdef MIPS_MULTICYCLE_JAL_EN
        // PC already holds PC+4; route it to write data via ALU with B=0 path unused
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        instr_done = 1'b1;
`endif
        state_d = StFetch;
      end

      default: begin
        // Unused codes 13-15 recover to FETCH with all strobes low
        state_d = StFetch;
      end
    endcase

    // Write strobes must stay quiet for the whole time reset is held
    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

  // Shared memory port: never read and write at once
  assert property (@(posedge clock) disable iff (!reset) !(MemRead && MemWrite));

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control. Each instruction is expanded
// from its class into a list of expected cycles (state, inputs, strobes),
// then played against the DUT one cycle at a time.
module tb_mips_multicycle_control;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] PCSource, ALUSrcB, RegDst;
  logic [2:0] ula_operation;
  logic [3:0] state;
  logic       instr_done;

  mips_multicycle_control dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .BranchNE      (BranchNE),
    .IorD          (IorD),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .IRWrite       (IRWrite),
    .ALUSrcA       (ALUSrcA),
    .RegWrite      (RegWrite),
    .PCSource      (PCSource),
    .ALUSrcB       (ALUSrcB),
    .ula_operation (ula_operation),
    .RegDst        (RegDst),
    .state         (state),
    .instr_done    (instr_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [19:0] outs;
  assign outs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 ALUSrcA, RegWrite, PCSource, ALUSrcB, ula_operation, RegDst, instr_done};

  localparam logic [19:0] Pcw  = 20'h80000;
  localparam logic [19:0] Pcwc = 20'h40000;
  localparam logic [19:0] Bne  = 20'h20000;
  localparam logic [19:0] Iord = 20'h10000;
  localparam logic [19:0] Mrd  = 20'h08000;
  localparam logic [19:0] Mwr  = 20'h04000;
  localparam logic [19:0] M2r  = 20'h02000;
  localparam logic [19:0] Irw  = 20'h01000;
  localparam logic [19:0] Srca = 20'h00800;
  localparam logic [19:0] Rgw  = 20'h00400;
  localparam logic [19:0] Done = 20'h00001;

  function automatic logic [19:0] pcs(input logic [1:0] v);  return 20'(v) << 8; endfunction
  function automatic logic [19:0] srcb(input logic [1:0] v); return 20'(v) << 6; endfunction
  function automatic logic [19:0] ula(input logic [2:0] v);  return 20'(v) << 3; endfunction
  function automatic logic [19:0] rdst(input logic [1:0] v); return 20'(v) << 1; endfunction

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic [5:0]  op;
    logic [19:0] o;
  } cyc_t;

  cyc_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op,
                      input logic [19:0] o);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op; c.o = o;
    q.push_back(c);
  endtask

  // Expand one instruction into its expected cycles
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    logic legal;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) ||
            (op == 6'h05) || (op == 6'h02) || (op == 6'h08);
`ifdef MIPS_MULTICYCLE_JAL_EN
    if (op == 6'h03) legal = 1'b1;
`endif
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, rnd_op(), Mrd | srcb(2'b01));
    push(4'd0, 1'b1, rnd_op(), Mrd | Irw | Pcw | srcb(2'b01));
    push(4'd1, 1'($urandom), op, srcb(2'b11) | (legal ? 20'h0 : Done));
    if (legal) begin
      case (op)
        6'h23: begin
          push(4'd2, 1'($urandom), op, Srca | srcb(2'b10));
          for (int i = 0; i < mw; i++) push(4'd3, 1'b0, rnd_op(), Mrd | Iord);
          push(4'd3, 1'b1, rnd_op(), Mrd | Iord);
          push(4'd4, 1'($urandom), rnd_op(), Rgw | M2r | Done);
        end
        6'h2b: begin
          push(4'd2, 1'($urandom), op, Srca | srcb(2'b10));
          for (int i = 0; i < mw; i++) push(4'd5, 1'b0, rnd_op(), Mwr | Iord);
          push(4'd5, 1'b1, rnd_op(), Mwr | Iord | Done);
        end
        6'h00: begin
          push(4'd6, 1'($urandom), rnd_op(), Srca | ula(3'b010));
          push(4'd7, 1'($urandom), rnd_op(), Rgw | rdst(2'b01) | Done);
        end
        6'h08: begin
          push(4'd10, 1'($urandom), rnd_op(), Srca | srcb(2'b10));
          push(4'd11, 1'($urandom), rnd_op(), Rgw | Done);
        end
        6'h04, 6'h05: begin
          push(4'd8, 1'($urandom), rnd_op(),
               Srca | ula(3'b001) | Pcwc | pcs(2'b01) | ((op == 6'h05) ? Bne : 20'h0) | Done);
        end
        6'h02: push(4'd9, 1'($urandom), rnd_op(), Pcw | pcs(2'b10) | Done);
        default: push(4'd12, 1'($urandom), rnd_op(), Pcw | pcs(2'b10) | Rgw | rdst(2'b10) | Done);
      endcase
    end
  endtask

  // Play up to limit queued cycles, then drop the queue
  task automatic apply(input int limit);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      @(negedge clock);
      opcode    = q[i].op;
      mem_ready = q[i].mr;
      #1;
      check_eq($sformatf("state[op=%0h]", q[i].op), 32'(state), 32'(q[i].st));
      check_eq($sformatf("strobes[st=%0d]", q[i].st), 32'(outs), 32'(q[i].o));
    end
    q.delete();
  endtask

  task automatic run(input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw);
    apply(1000);
  endtask

  // Reset held: FETCH with write strobes suppressed even when memory is ready
  task automatic check_reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      mem_ready = 1'b1;
      opcode    = rnd_op();
      #1;
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_strobes", 32'(outs), 32'(Mrd | srcb(2'b01)));
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    mem_ready = 1'b0;
    reset     = 1'b1;
  endtask

  logic [5:0] op_tab [8];

  initial begin
    op_tab[0] = 6'h00; op_tab[1] = 6'h23; op_tab[2] = 6'h2b; op_tab[3] = 6'h04;
    op_tab[4] = 6'h05; op_tab[5] = 6'h02; op_tab[6] = 6'h03; op_tab[7] = 6'h08;

    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h23;
    #3;
    check_eq("por_state", 32'(state), 32'd0);
    check_eq("por_strobes", 32'(outs), 32'(Mrd | srcb(2'b01)));
    check_reset_cycles(2);
    release_reset();

    // Directed cases
    run(6'h23, 0, 0);   // lw, memory always ready
    run(6'h2b, 0, 3);   // sw with three wait cycles
    run(6'h04, 1, 0);   // beq
    run(6'h05, 0, 0);   // bne
    run(6'h3f, 0, 0);   // illegal
    run(6'h03, 0, 0);   // jal (depends on build option)
    run(6'h00, 2, 0);
    run(6'h08, 0, 0);
    run(6'h02, 0, 0);

    // Reset during a MEMREAD wait abandons the load
    build(6'h23, 0, 5);
    apply(5);
    #2;
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check_eq("midrst_state", 32'(state), 32'd0);
    check_eq("midrst_strobes", 32'(outs), 32'(Mrd | srcb(2'b01)));
    check_reset_cycles(3);
    release_reset();
    run(6'h23, 0, 1);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = ($urandom_range(3) == 0) ? rnd_op() : op_tab[$urandom_range(7)];
      run(op, $urandom_range(2), $urandom_range(3));
      if ($urandom_range(40) == 0) begin
        build(rnd_op(), $urandom_range(2), $urandom_range(3));
        apply($urandom_range(1, 4));
        #2;
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        check_eq("rndrst_state", 32'(state), 32'd0);
        check_eq("rndrst_strobes", 32'(outs), 32'(Mrd | srcb(2'b01)));
        check_reset_cycles(1);
        release_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have ports: clock  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-003 SHALL have ports: opcode  in  6  instruction[31:26] from instruction register.
REQ-004 SHALL have ports: mem_ready  in  1  shared memory access complete this cycle.
REQ-005 SHALL have ports: PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite  out  1 each  datapath strobes.
REQ-006 SHALL have ports: PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-007 SHALL have ports: ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 SHALL have ports: ula_operation  out  3  000 add, 001 sub, 010 R-type (funct decoded by ula_control).
REQ-009 SHALL have ports: RegDst  out  2  00 rt, 01 rd, 10 $31.
REQ-010 SHALL have ports: state  out  4  current state code; instr_done  out  1  one-cycle retire pulse.

Function
REQ-011 SHALL be a Moore FSM with codes: FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JAL 12; codes 13-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-012 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ula_operation=000, PCSource=00; PCWrite and IRWrite SHALL assert only when mem_ready=1; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ula_operation=000 (branch target precompute); next by opcode: 000000->REXEC, 100011/101011->MEMADDR, 000100/000101->BRANCH, 000010->JUMP, 000011->JAL, 001000->IEXEC, any other->FETCH with no writes (treated as NOP, instr_done=1).
REQ-014 MEMADDR: ALUSrcA=1, ALUSrcB=10, add; lw->MEMREAD, sw->MEMWRITE.
REQ-015 MEMREAD: MemRead=1, IorD=1; hold while mem_ready=0; then MEMWB.
REQ-016 MEMWB: RegWrite=1, RegDst=00, MemtoReg=1; ->FETCH.
REQ-017 MEMWRITE: MemWrite=1, IorD=1; hold while mem_ready=0; then FETCH.
REQ-018 REXEC: ALUSrcA=1, ALUSrcB=00, ula_operation=010; ->RWB. RWB: RegWrite=1, RegDst=01, MemtoReg=0; ->FETCH.
REQ-019 IEXEC: ALUSrcA=1, ALUSrcB=10, add; ->IWB. IWB: RegWrite=1, RegDst=00, MemtoReg=0; ->FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, BranchNE=1 iff opcode=000101; ->FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10; ->FETCH.
REQ-022 instr_done SHALL pulse 1 cycle in the final state of every instruction (MEMWB, MEMWRITE with mem_ready, RWB, IWB, BRANCH, JUMP, JAL, illegal-opcode DECODE).
REQ-023 Any strobe not listed for a state SHALL be 0; MemRead and MemWrite SHALL never be 1 together.
REQ-024 opcode SHALL be sampled only in DECODE and MEMADDR; changes elsewhere SHALL have no effect.

Reset
REQ-025 reset low SHALL force state=FETCH asynchronously; all strobes except FETCH's Moore outputs with mem_ready gating SHALL be 0; PCWrite, IRWrite, RegWrite, MemWrite, instr_done SHALL be 0 while reset is low.
REQ-026 Reset asserted mid-instruction (including during a mem_ready wait) SHALL abandon it; no RegWrite/MemWrite SHALL occur after reset assertion.
REQ-027 First fetch SHALL begin on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MIPS_MULTICYCLE_JAL_EN defined: JAL state SHALL assert PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=0, ALUSrcA=0, ALUSrcB=00 (PC+4 routed to write data); ->FETCH.
REQ-029 Macro undefined: opcode 000011 SHALL be treated as illegal (REQ-013), state JAL unreachable.

Verification
REQ-030 lw, mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; instr_done at state 4.
REQ-031 sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite held 4 cycles, instr_done once, then FETCH.
REQ-032 beq then bne -> PCWriteCond=1, PCSource=01, BranchNE 0 then 1; 3 cycles each.
REQ-033 opcode 111111 -> FETCH,DECODE,FETCH; no PCWrite beyond fetch, no RegWrite/MemWrite; instr_done=1.
REQ-034 reset low during MEMREAD wait -> state=0 same cycle, RegWrite never asserts; fetch resumes after release.
REQ-035 jal with macro on -> states 0,1,12,0, RegDst=10, RegWrite=1; macro off -> 0,1,0, RegWrite=0.
